ip_dest_extract: RTL and testbench
==================================

# ip_dest_extract

Stream stage directly upstream of the output-port override stage in the router's output port lookup path. It parses the Ethernet/IPv4 header across the first two 256-bit beats of each packet and extracts the destination IP. It classifies the packet against four configurable local addresses plus broadcast and header-sanity checks, and drives a per-packet hit vector and the destination IP. Both are held stable while that packet is emitted downstream.

## Interface
- C_M_AXIS_DATA_WIDTH, 256, output stream data width (fixed at 256; header offsets depend on it)
- C_S_AXIS_DATA_WIDTH, 256, input stream data width
- C_M_AXIS_TUSER_WIDTH, 128, output TUSER width
- C_S_AXIS_TUSER_WIDTH, 128, input TUSER width
- AXI_ACLK  in  1  sole clock, rising edge
- AXI_RESET  in  1  reset, synchronous, active-high
- S_AXIS_TDATA / TSTRB / TUSER / TVALID / TLAST  in  256/32/128/1/1  input stream
- S_AXIS_TREADY  out  1  input ready
- M_AXIS_TDATA / TSTRB / TUSER / TVALID / TLAST  out  256/32/128/1/1  output stream (TUSER passed unmodified)
- M_AXIS_TREADY  in  1  output ready
- local_ip0..local_ip3  in  32 each  router interface addresses
- local_ip_en  in  4  per-address match enable
- dest_ip  out  32  destination IP of current packet
- cpu_hit  out  6  classification vector of current packet
- pkt_count, hit_count, bad_count  out  32 each  statistics

## Operation
- Beat-0 fields: ethertype [159:144]; version [143:140]; IHL [139:136]; TTL [79:72]; dest IP high half [15:0]. Beat-1 field: dest IP low half [255:240].
- cpu_hit bits:
  - bit i (i = 0..3): local_ip_en[i] && dest_ip == local_ip_i.
  - bit 4: dest_ip == 32'hFFFFFFFF.
  - bit 5: bad header, i.e. ethertype != 16'h0800, or version != 4, or IHL < 5, or TTL <= 1, or the packet is a single beat (runt).
- Runt packet: dest_ip = {beat0[15:0], 16'h0000}; bits 0..4 still evaluated on that value.
- FSM states:
  - WAIT_B0: S_TREADY=1. On handshake, store beat 0. If TLAST, compute result and go to EMIT_B0; otherwise go to WAIT_B1.
  - WAIT_B1: S_TREADY=1. On handshake, store beat 1, compute result, go to EMIT_B0.
  - EMIT_B0: M_TVALID=1 with beat 0. On M handshake, go to WAIT_B0 if beat 0 was last, else EMIT_B1.
  - EMIT_B1: M_TVALID=1 with beat 1. On M handshake, go to WAIT_B0 if beat 1 was last, else PASS.
  - PASS: combinational pass-through; M_AXIS_* = S_AXIS_*, S_TREADY = M_TREADY. On a TLAST handshake, go to WAIT_B0.
- S_TREADY=0 in EMIT_B0 and EMIT_B1.
- Result register (dest_ip, cpu_hit) loads only at result computation. It is held through EMIT and PASS and until the next packet's computation.
- Counters, each 32-bit, wrap from FFFFFFFF to 0, incrementing at result computation:
  - pkt_count: +1 per packet.
  - hit_count: +1 if any of bits 0..4 is set.
  - bad_count: +1 if bit 5 is set.

## Timing
- Reset values: M_AXIS_TVALID=0, S_AXIS_TREADY=0 while reset asserted, dest_ip=0, cpu_hit=0, all counters 0, state WAIT_B0. M_AXIS data outputs are don't-care while TVALID=0.
- Reset mid-packet discards the buffered beats and partial PASS state. The first beat accepted after reset is treated as a packet start.
- Result is visible in the cycle M_AXIS_TVALID first rises for the packet: one cycle after beat-1 acceptance, or one cycle after beat-0 acceptance for a runt.
- Per-packet latency: 2 cycles for beat 0 with no backpressure. Throughput costs 2 idle input cycles per packet.
- M_AXIS_TVALID, once high in EMIT states, stays high with stable data until M_AXIS_TREADY.
- local_ip*/local_ip_en are sampled at result computation only; changes mid-packet do not alter the held result.

## Test plan
- 3-beat IPv4 packet, TTL=64, dest 10.0.1.1, local_ip1=0x0A000101, en=4'b0010:
  - dest_ip=0x0A000101, cpu_hit=6'b000010 from first M beat through TLAST.
  - pkt_count=1, hit_count=1.
  - All 3 beats appear on output bit-exact in order.
- ARP packet (ethertype 0x0806), 2 beats: cpu_hit=6'b100000, bad_count=1; output ends on beat 1 with TLAST.
- IPv4 with TTL=1, dest 255.255.255.255: cpu_hit=6'b110000.
- Single-beat runt with beat0[15:0]=16'h0A00: dest_ip=0x0A000000, bit 5 set, FSM returns to WAIT_B0 after one output beat.
- Random M_AXIS_TREADY backpressure over 100 back-to-back packets of 1–8 beats:
  - Output stream equals input stream.
  - dest_ip/cpu_hit never change while a packet is in flight.
  - pkt_count=100.
- Reset asserted in PASS mid-packet: next cycle M_AXIS_TVALID=0 and counters=0. A following 2-beat packet is emitted correctly.

Source files
------------

// File: rtl/ip_dest_extract.sv
// Pulls the IPv4 destination out of the first two 256-bit beats, classifies it, then replays the buffered beats and passes the rest through.
// First output beat trails beat-0 acceptance by two cycles; input is stalled while buffered beats are replayed, then tracks M_AXIS_TREADY.
module ip_dest_extract #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                                AXI_ACLK,
    input  logic                                AXI_RESET,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
    input  logic                                S_AXIS_TVALID,
    input  logic                                S_AXIS_TLAST,
    output logic                                S_AXIS_TREADY,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
    output logic                                M_AXIS_TVALID,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY,

    input  logic [31:0]                         local_ip0,
    input  logic [31:0]                         local_ip1,
    input  logic [31:0]                         local_ip2,
    input  logic [31:0]                         local_ip3,
    input  logic [3:0]                          local_ip_en,

    output logic [31:0]                         dest_ip,
    output logic [5:0]                          cpu_hit,
    output logic [31:0]                         pkt_count,
    output logic [31:0]                         hit_count,
    output logic [31:0]                         bad_count
);

    typedef enum logic [2:0] {
        WAIT_B0,
        WAIT_B1,
        EMIT_B0,
        EMIT_B1,
        PASS
    } state_t;

    state_t state_q, state_d;

    logic [C_S_AXIS_DATA_WIDTH-1:0]   b0_dat_q, b1_dat_q;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0] b0_strb_q, b1_strb_q;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  b0_user_q, b1_user_q;
    logic                             b0_last_q, b1_last_q;

    logic [31:0] dest_ip_q, dest_ip_d;
    logic [5:0]  cpu_hit_q, cpu_hit_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] bad_cnt_q, bad_cnt_d;

    logic        s_rdy, m_vld, s_hs, m_hs;
    logic        calc_vld, calc_runt;
    logic [15:0] f_etype, f_dst_hi, f_dst_lo;
    logic [3:0]  f_ver, f_ihl;
    logic [7:0]  f_ttl;
    logic [31:0] calc_dest;
    logic [5:0]  calc_hit;

    // Handshake and state sequencing
    always_comb begin
        s_rdy   = 1'b0;
        m_vld   = 1'b0;
        state_d = state_q;
        case (state_q)
            WAIT_B0: begin
                s_rdy = 1'b1;
                if (S_AXIS_TVALID) begin
                    state_d = S_AXIS_TLAST ? EMIT_B0 : WAIT_B1;
                end
            end
            WAIT_B1: begin
                s_rdy = 1'b1;
                if (S_AXIS_TVALID) begin
                    state_d = EMIT_B0;
                end
            end
            EMIT_B0: begin
                m_vld = 1'b1;
                if (M_AXIS_TREADY) begin
                    state_d = b0_last_q ? WAIT_B0 : EMIT_B1;
                end
            end
            EMIT_B1: begin
                m_vld = 1'b1;
                if (M_AXIS_TREADY) begin
                    state_d = b1_last_q ? WAIT_B0 : PASS;
                end
            end
            PASS: begin
                s_rdy = M_AXIS_TREADY;
                m_vld = S_AXIS_TVALID;
                if (S_AXIS_TVALID && M_AXIS_TREADY && S_AXIS_TLAST) begin
                    state_d = WAIT_B0;
                end
            end
            default: state_d = WAIT_B0;
        endcase
        if (AXI_RESET) begin
            s_rdy = 1'b0;
            m_vld = 1'b0;
        end
    end

    assign s_hs          = S_AXIS_TVALID && s_rdy;
    assign m_hs          = m_vld && M_AXIS_TREADY;
    assign S_AXIS_TREADY = s_rdy;
    assign M_AXIS_TVALID = m_vld;

    // A runt classifies straight off the input bus; otherwise beat 0 comes from the buffer.
    always_comb begin
        calc_vld  = 1'b0;
        calc_runt = 1'b0;
        if (state_q == WAIT_B0 && s_hs && S_AXIS_TLAST) begin
            calc_vld  = 1'b1;
            calc_runt = 1'b1;
        end else if (state_q == WAIT_B1 && s_hs) begin
            calc_vld  = 1'b1;
        end

        if (calc_runt) begin
            f_etype  = S_AXIS_TDATA[159:144];
            f_ver    = S_AXIS_TDATA[143:140];
            f_ihl    = S_AXIS_TDATA[139:136];
            f_ttl    = S_AXIS_TDATA[79:72];
            f_dst_hi = S_AXIS_TDATA[15:0];
            f_dst_lo = 16'h0000;
        end else begin
            f_etype  = b0_dat_q[159:144];
            f_ver    = b0_dat_q[143:140];
            f_ihl    = b0_dat_q[139:136];
            f_ttl    = b0_dat_q[79:72];
            f_dst_hi = b0_dat_q[15:0];
            f_dst_lo = S_AXIS_TDATA[255:240];
        end

        calc_dest   = {f_dst_hi, f_dst_lo};
        calc_hit[0] = local_ip_en[0] && (calc_dest == local_ip0);
        calc_hit[1] = local_ip_en[1] && (calc_dest == local_ip1);
        calc_hit[2] = local_ip_en[2] && (calc_dest == local_ip2);
        calc_hit[3] = local_ip_en[3] && (calc_dest == local_ip3);
        calc_hit[4] = (calc_dest == 32'hFFFF_FFFF);
        calc_hit[5] = (f_etype != 16'h0800) || (f_ver != 4'd4) || (f_ihl < 4'd5)
                   || (f_ttl <= 8'd1) || calc_runt;
    end

    always_comb begin
        dest_ip_d = dest_ip_q;
        cpu_hit_d = cpu_hit_q;
        pkt_cnt_d = pkt_cnt_q;
        hit_cnt_d = hit_cnt_q;
        bad_cnt_d = bad_cnt_q;
        if (calc_vld) begin
            dest_ip_d = calc_dest;
            cpu_hit_d = calc_hit;
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            hit_cnt_d = hit_cnt_q + {31'd0, |calc_hit[4:0]};
            bad_cnt_d = bad_cnt_q + {31'd0, calc_hit[5]};
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            state_q   <= WAIT_B0;
            dest_ip_q <= 32'd0;
            cpu_hit_q <= 6'd0;
            pkt_cnt_q <= 32'd0;
            hit_cnt_q <= 32'd0;
            bad_cnt_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            dest_ip_q <= dest_ip_d;
            cpu_hit_q <= cpu_hit_d;
            pkt_cnt_q <= pkt_cnt_d;
            hit_cnt_q <= hit_cnt_d;
            bad_cnt_q <= bad_cnt_d;
        end
    end

    // Beat buffers carry no reset: they are only read after being written by the same packet.
    always_ff @(posedge AXI_ACLK) begin
        if (state_q == WAIT_B0 && s_hs) begin
            b0_dat_q  <= S_AXIS_TDATA;
            b0_strb_q <= S_AXIS_TSTRB;
            b0_user_q <= S_AXIS_TUSER;
            b0_last_q <= S_AXIS_TLAST;
        end
        if (state_q == WAIT_B1 && s_hs) begin
            b1_dat_q  <= S_AXIS_TDATA;
            b1_strb_q <= S_AXIS_TSTRB;
            b1_user_q <= S_AXIS_TUSER;
            b1_last_q <= S_AXIS_TLAST;
        end
    end

    always_comb begin
        M_AXIS_TDATA = S_AXIS_TDATA;
        M_AXIS_TSTRB = S_AXIS_TSTRB;
        M_AXIS_TUSER = S_AXIS_TUSER;
        M_AXIS_TLAST = S_AXIS_TLAST;
        case (state_q)
            EMIT_B0: begin
                M_AXIS_TDATA = b0_dat_q;
                M_AXIS_TSTRB = b0_strb_q;
                M_AXIS_TUSER = b0_user_q;
                M_AXIS_TLAST = b0_last_q;
            end
            EMIT_B1: begin
                M_AXIS_TDATA = b1_dat_q;
                M_AXIS_TSTRB = b1_strb_q;
                M_AXIS_TUSER = b1_user_q;
                M_AXIS_TLAST = b1_last_q;
            end
            default: ;
        endcase
    end

    assign dest_ip   = dest_ip_q;
    assign cpu_hit   = cpu_hit_q;
    assign pkt_count = pkt_cnt_q;
    assign hit_count = hit_cnt_q;
    assign bad_count = bad_cnt_q;

endmodule

// File: tb/tb_ip_dest_extract.sv
// Directed bench for ip_dest_extract: table of header vectors, timing/reset sequences, and a backpressured packet soak.
module tb_ip_dest_extract;

    typedef logic [416:0] beat_t;
    typedef struct packed {
        logic        chk;
        logic [31:0] d;
        logic [5:0]  h;
    } res_t;
    typedef struct {
        logic [15:0] etype;
        logic [3:0]  ver;
        logic [3:0]  ihl;
        logic [7:0]  ttl;
        logic [31:0] dst;
        int          nb;
        logic [31:0] l0, l1, l2, l3;
        logic [3:0]  en;
        logic [31:0] exp_dst;
        logic [5:0]  exp_hit;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] s_dat = '0;
    logic [31:0]  s_strb = '0;
    logic [127:0] s_user = '0;
    logic         s_vld = 1'b0, s_last = 1'b0, s_rdy;
    logic [255:0] m_dat;
    logic [31:0]  m_strb;
    logic [127:0] m_user;
    logic         m_vld, m_last;
    logic         m_rdy = 1'b0;
    logic [31:0]  lip0 = '0, lip1 = '0, lip2 = '0, lip3 = '0;
    logic [3:0]   lip_en = '0;
    logic [31:0]  dest_ip, pkt_count, hit_count, bad_count;
    logic [5:0]   cpu_hit;

    int    n_chk = 0, n_fail = 0;
    beat_t exp_beat[$];
    res_t  exp_res[$];
    bit    bp = 1'b0, churn = 1'b0, in_pkt = 1'b0;
    logic [31:0] held_d;
    logic [5:0]  held_h;
    vec_t  vt[8];

    always #5 clk = ~clk;

    ip_dest_extract dut (
        .AXI_ACLK(clk), .AXI_RESET(rst),
        .S_AXIS_TDATA(s_dat), .S_AXIS_TSTRB(s_strb), .S_AXIS_TUSER(s_user),
        .S_AXIS_TVALID(s_vld), .S_AXIS_TLAST(s_last), .S_AXIS_TREADY(s_rdy),
        .M_AXIS_TDATA(m_dat), .M_AXIS_TSTRB(m_strb), .M_AXIS_TUSER(m_user),
        .M_AXIS_TVALID(m_vld), .M_AXIS_TLAST(m_last), .M_AXIS_TREADY(m_rdy),
        .local_ip0(lip0), .local_ip1(lip1), .local_ip2(lip2), .local_ip3(lip3),
        .local_ip_en(lip_en),
        .dest_ip(dest_ip), .cpu_hit(cpu_hit),
        .pkt_count(pkt_count), .hit_count(hit_count), .bad_count(bad_count)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_beat(input beat_t act, input beat_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL beat: got %0h expected %0h", act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Output monitor: ready generation, beat scoreboard, per-packet result and hold checks.
    initial begin
        res_t r;
        forever begin
            @(posedge clk);
            #1 m_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (rst) begin
                in_pkt = 1'b0;
            end else begin
                if (in_pkt) begin
                    check("hold_dest", dest_ip, held_d);
                    check("hold_hit", 32'(cpu_hit), 32'(held_h));
                end
                if (m_vld && m_rdy) begin
                    if (exp_beat.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL extra_beat: got %0h expected none", m_dat);
                    end else begin
                        check_beat({m_dat, m_strb, m_user, m_last}, exp_beat.pop_front());
                    end
                    if (!in_pkt) begin
                        in_pkt = 1'b1;
                        held_d = dest_ip;
                        held_h = cpu_hit;
                        if (exp_res.size() > 0) begin
                            r = exp_res.pop_front();
                            if (r.chk) begin
                                check("dest_ip", dest_ip, r.d);
                                check("cpu_hit", 32'(cpu_hit), 32'(r.h));
                            end
                        end
                    end
                    if (m_last) in_pkt = 1'b0;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
    task automatic send_beat(input logic [255:0] d, input logic last);
        int t = 0;
        s_dat  = d;
        s_strb = $urandom;
        s_user = {$urandom, $urandom, $urandom, $urandom};
        s_last = last;
        s_vld  = 1'b1;
        exp_beat.push_back({s_dat, s_strb, s_user, s_last});
        @(negedge clk);
        while (!s_rdy && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!s_rdy) check("s_ready_timeout", 32'(s_rdy), 32'd1);
        @(posedge clk);
        #1 s_vld = 1'b0;
    endtask

    task automatic send_pkt(input logic [15:0] et, input logic [3:0] ver, input logic [3:0] ihl,
                            input logic [7:0] ttl, input logic [31:0] dst, input int nb,
                            input int nsend, input logic chk, input logic [31:0] ed,
                            input logic [5:0] eh);
        logic [255:0] d;
        exp_res.push_back({chk, ed, eh});
        for (int i = 0; i < nb && i < nsend; i++) begin
            d = rand256();
            if (i == 0) begin
                d[159:144] = et;
                d[143:140] = ver;
                d[139:136] = ihl;
                d[79:72]   = ttl;
                d[15:0]    = dst[31:16];
            end
            if (i == 1) d[255:240] = dst[15:0];
            if (churn) begin
                lip0   = $urandom_range(0, 1) ? dst : $urandom;
                lip_en = 4'($urandom);
            end
            send_beat(d, i == nb - 1);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_beat.size() != 0 || in_pkt) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(exp_beat.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{16'h0800, 4'd4, 4'd5,  8'd64,  32'h0A000101, 3, 32'h0, 32'h0A000101, 32'h0, 32'h0,
                  4'b0010, 32'h0A000101, 6'b000010};
        vt[1] = '{16'h0806, 4'd4, 4'd5,  8'd64,  32'hC0A80001, 2, 32'h0, 32'h0, 32'h0, 32'h0,
                  4'b0000, 32'hC0A80001, 6'b100000};
        vt[2] = '{16'h0800, 4'd4, 4'd5,  8'd1,   32'hFFFFFFFF, 2, 32'h0, 32'h0, 32'h0, 32'h0,
                  4'b0000, 32'hFFFFFFFF, 6'b110000};
        vt[3] = '{16'h0800, 4'd4, 4'd5,  8'd64,  32'h0A00BEEF, 1, 32'h0A000000, 32'h0, 32'h0, 32'h0,
                  4'b0001, 32'h0A000000, 6'b100001};
        vt[4] = '{16'h0800, 4'd4, 4'd4,  8'd64,  32'h01020304, 4, 32'h0, 32'h0, 32'h01020304, 32'h0,
                  4'b0100, 32'h01020304, 6'b100100};
        vt[5] = '{16'h0800, 4'd6, 4'd5,  8'd64,  32'h08080808, 2, 32'h0, 32'h0, 32'h0, 32'h0,
                  4'b0000, 32'h08080808, 6'b100000};
        vt[6] = '{16'h0800, 4'd4, 4'd5,  8'd2,   32'hAC100001, 5, 32'hAC100001, 32'hAC100002, 32'h0,
                  32'hAC100001, 4'b1011, 32'hAC100001, 6'b001001};
        vt[7] = '{16'h0800, 4'd4, 4'd15, 8'd255, 32'hAC100005, 2, 32'h0, 32'h0, 32'hAC100005, 32'h0,
                  4'b1011, 32'hAC100005, 6'b000000};

        // Reset state
        @(negedge clk);
        check("rst_s_ready", 32'(s_rdy), 32'd0);
        check("rst_m_valid", 32'(m_vld), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_dest", dest_ip, 32'd0);
        check("rst_hit", 32'(cpu_hit), 32'd0);
        check("rst_pkt", pkt_count, 32'd0);
        check("rst_hitc", hit_count, 32'd0);
        check("rst_bad", bad_count, 32'd0);
        check("idle_s_ready", 32'(s_rdy), 32'd1);

        // Header classification table
        for (int i = 0; i < 8; i++) begin
            lip0 = vt[i].l0; lip1 = vt[i].l1; lip2 = vt[i].l2; lip3 = vt[i].l3;
            lip_en = vt[i].en;
            @(posedge clk);
            #1;
            send_pkt(vt[i].etype, vt[i].ver, vt[i].ihl, vt[i].ttl, vt[i].dst, vt[i].nb, vt[i].nb,
                     1'b1, vt[i].exp_dst, vt[i].exp_hit);
            drain();
        end
        check("tbl_pkt", pkt_count, 32'd8);
        check("tbl_hitc", hit_count, 32'd5);
        check("tbl_bad", bad_count, 32'd5);

        // Runt: one output beat, then straight back to accepting input
        lip_en = 4'b0000;
        @(posedge clk);
        #1;
        send_pkt(16'h0800, 4'd4, 4'd5, 8'd64, 32'hC0A81234, 1, 1, 1'b1, 32'hC0A80000, 6'b100000);
        @(negedge clk);
        check("runt_m_valid", 32'(m_vld), 32'd1);
        check("runt_m_last", 32'(m_last), 32'd1);
        check("runt_s_stall", 32'(s_rdy), 32'd0);
        @(negedge clk);
        check("runt_ret_s_ready", 32'(s_rdy), 32'd1);
        check("runt_ret_m_valid", 32'(m_vld), 32'd0);
        drain();

        // Two-beat packet: output valid right after beat-1 acceptance
        @(posedge clk);
        #1;
        send_pkt(16'h0800, 4'd4, 4'd5, 8'd64, 32'h0B0C0D0E, 2, 2, 1'b1, 32'h0B0C0D0E, 6'b000000);
        @(negedge clk);
        check("lat_m_valid", 32'(m_vld), 32'd1);
        check("lat_s_stall", 32'(s_rdy), 32'd0);
        drain();
        check("seq_pkt", pkt_count, 32'd10);
        check("seq_hitc", hit_count, 32'd5);
        check("seq_bad", bad_count, 32'd6);

        // Reset while passing through the tail of a 4-beat packet
        @(posedge clk);
        #1;
        send_pkt(16'h0800, 4'd4, 4'd5, 8'd64, 32'h0A000101, 4, 3, 1'b0, 32'h0, 6'h0);
        rst = 1'b1;
        s_dat = rand256();
        s_last = 1'b1;
        s_vld = 1'b1;
        @(negedge clk);
        check("mid_rst_s_ready", 32'(s_rdy), 32'd0);
        check("mid_rst_m_valid", 32'(m_vld), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        s_vld = 1'b0;
        @(negedge clk);
        check("post_rst_m_valid", 32'(m_vld), 32'd0);
        check("post_rst_pkt", pkt_count, 32'd0);
        check("post_rst_hitc", hit_count, 32'd0);
        check("post_rst_bad", bad_count, 32'd0);
        check("post_rst_dest", dest_ip, 32'd0);
        check("post_rst_queue", 32'(exp_beat.size()), 32'd0);
        lip1 = 32'h0A000101;
        lip_en = 4'b0010;
        @(posedge clk);
        #1;
        send_pkt(16'h0800, 4'd4, 4'd5, 8'd64, 32'h0A000101, 2, 2, 1'b1, 32'h0A000101, 6'b000010);
        drain();
        check("post_rst_pkt1", pkt_count, 32'd1);
        check("post_rst_hit1", hit_count, 32'd1);

        // Soak: back-to-back packets under random backpressure with churning local addresses
        pulse_reset();
        bp = 1'b1;
        churn = 1'b1;
        for (int p = 0; p < 100; p++) begin
            send_pkt($urandom_range(0, 3) == 0 ? 16'h0806 : 16'h0800, 4'd4, 4'd5,
                     8'($urandom), $urandom, $urandom_range(1, 8), 8, 1'b0, 32'h0, 6'h0);
        end
        drain();
        check("soak_pkt", pkt_count, 32'd100);
        check("soak_res_queue", 32'(exp_res.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
